aes_key_expand_dec: RTL and testbench

Round-key generator that sits directly upstream of the AES decrypt core. It accepts a 128-bit cipher key and expands it iteratively, one round key per clock, into an 11-entry round-key store. It then serves the decrypt core: round key 10 on a dedicated port, and round key `10 - round_num` on the per-round port, read combinationally from `round_num`. The decrypt core must not be started while `key_ready` is low.

---
 rtl/aes_pkg.sv | 43 ++++
 rtl/aes_key_expand_step.sv | 32 +++
 rtl/aes_key_expand_dec.sv | 107 ++++++++++
 tb/tb_aes_key_expand_dec.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: round count, key-schedule state encoding, round
// constants and the forward S-box used by SubWord.
package aes_pkg;

    localparam int AES_NR = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } key_state_t;

    // Entry 0 is never used by the schedule; it only pads the array so that
    // RCON[step] lines up with the step counter.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: previous round key + rcon -> next round key.
// Purely combinational; the XOR chain n0..n3 is the tail of the critical path.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [7:0]   rcon,
    output logic [127:0] next_key
);

    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot_w, sub_w, t_w;
    logic [31:0] n0, n1, n2, n3;

    // SubWord(RotWord(p3)) ^ rcon, then the running XOR across the words
    always_comb begin
        p0     = prev_key[127:96];
        p1     = prev_key[95:64];
        p2     = prev_key[63:32];
        p3     = prev_key[31:0];
        rot_w  = {p3[23:0], p3[31:24]};
        sub_w  = {sbox_fwd(rot_w[31:24]), sbox_fwd(rot_w[23:16]),
                  sbox_fwd(rot_w[15:8]),  sbox_fwd(rot_w[7:0])};
        t_w    = sub_w ^ {rcon, 24'h0};
        n0     = p0 ^ t_w;
        n1     = n0 ^ p1;
        n2     = n1 ^ p2;
        n3     = n2 ^ p3;
        next_key = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_key_expand_dec.sv
// AES-128 round-key generator for the decrypt core. Expands one round key
// per clock into an 11-slot store, then serves slots combinationally.
//
// state  | meaning
// IDLE   | after reset, no valid key set
// EXPAND | writing rk[step] from rk[step-1], one slot per cycle
// READY  | all 11 slots valid, held until the next key_load
module aes_key_expand_dec
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] cipher_key,
    input  logic         key_load,
    input  logic [3:0]   round_num,
    output logic         key_ready,
    output logic         key_busy,
    output logic [127:0] round_key_10,
    output logic [127:0] round_key
);

    key_state_t   state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [127:0] rk_q [0:NR];
    logic [127:0] rk_d [0:NR];

    logic [127:0] prev_key;
    logic [7:0]   rcon_cur;
    logic [127:0] next_key;

    // Select the source slot and rcon for the current step; a decode rather
    // than a computed index so step values outside 1..NR select nothing.
    always_comb begin
        prev_key = '0;
        rcon_cur = '0;
        for (int i = 1; i <= NR; i++) begin
            if (step_q == 4'(i)) begin
                prev_key = rk_q[i-1];
                rcon_cur = RCON[i];
            end
        end
    end

    aes_key_expand_step u_step (
        .prev_key (prev_key),
        .rcon     (rcon_cur),
        .next_key (next_key)
    );

    // Next-state logic: key_load restarts from any state, EXPAND walks the store
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rk_d    = rk_q;
        if (key_load) begin
            rk_d[0] = cipher_key;
            step_d  = 4'd1;
            state_d = EXPAND;
        end else if (state_q == EXPAND) begin
            for (int i = 1; i <= NR; i++) begin
                if (step_q == 4'(i)) begin
                    rk_d[i] = next_key;
                end
            end
            // Final slot written: stop counting so step stays at NR
            if (step_q == 4'(NR)) begin
                state_d = READY;
            end else begin
                step_d = step_q + 4'd1;
            end
        end
    end

    // State, counter and store registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            for (int i = 0; i <= NR; i++) begin
                rk_q[i] <= rk_d[i];
            end
        end
    end

    // Zero-latency read mux; out-of-range round_num falls back to the last slot
    always_comb begin
        round_key = rk_q[NR];
        for (int i = 1; i <= NR; i++) begin
            if (round_num == 4'(i)) begin
                round_key = rk_q[NR-i];
            end
        end
    end

    assign round_key_10 = rk_q[NR];
    assign key_busy     = (state_q == EXPAND);
    assign key_ready    = (state_q == READY);

endmodule

// File: tb/tb_aes_key_expand_dec.sv
// Bench for aes_key_expand_dec: reference key schedule derived from
// GF(2^8) arithmetic, directed scenarios plus random keys.
module tb_aes_key_expand_dec;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] cipher_key;
    logic         key_load;
    logic [3:0]   round_num;
    logic         key_ready;
    logic         key_busy;
    logic [127:0] round_key_10;
    logic [127:0] round_key;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]   ref_sbox [256];
    logic [127:0] exp_rk [11];

    always #5 clk = ~clk;

    aes_key_expand_dec dut (
        .clk          (clk),
        .reset        (reset),
        .cipher_key   (cipher_key),
        .key_load     (key_load),
        .round_num    (round_num),
        .key_ready    (key_ready),
        .key_busy     (key_busy),
        .round_key_10 (round_key_10),
        .round_key    (round_key)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ aa;
            aa = xtime(aa);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Textbook word-oriented AES-128 schedule, 44 words
    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {ref_sbox[tmp[31:24]], ref_sbox[tmp[23:16]],
                       ref_sbox[tmp[15:8]], ref_sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = xtime(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a one-cycle load; returns just after the load edge
    task automatic load_pulse(input logic [127:0] key);
        cipher_key = key;
        key_load   = 1'b1;
        @(negedge clk);
        key_load   = 1'b0;
    endtask

    // Expect busy for exactly 10 cycles after the load edge, then ready
    task automatic expect_expansion(input string tag);
        for (int k = 0; k < 10; k++) begin
            chk({tag, "_busy"}, 128'({key_busy, key_ready}), 128'(2'b10));
            @(negedge clk);
        end
        chk({tag, "_ready"}, 128'({key_busy, key_ready}), 128'(2'b01));
    endtask

    task automatic check_slots(input string tag);
        chk({tag, "_rk10"}, round_key_10, exp_rk[10]);
        for (int rn = 0; rn < 16; rn++) begin
            round_num = 4'(rn);
            #1;
            if (rn >= 1 && rn <= 10) chk($sformatf("%s_rn%0d", tag, rn), round_key, exp_rk[10-rn]);
            else                     chk($sformatf("%s_rn%0d", tag, rn), round_key, exp_rk[10]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_flags"}, 128'({key_busy, key_ready}), 128'(2'b00));
        chk({tag, "_rk10"}, round_key_10, 128'h0);
        round_num = 4'd3;
        #1;
        chk({tag, "_rk"}, round_key, 128'h0);
    endtask

    initial begin
        logic [127:0] key_a, key_b;
        build_sbox();
        reset      = 1'b1;
        key_load   = 1'b0;
        cipher_key = '0;
        round_num  = 4'd5;
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        // FIPS-197 key
        model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_pulse(128'h2b7e151628aed2a6abf7158809cf4f3c);
        expect_expansion("fips");
        chk("fips_rk10_const", round_key_10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        round_num = 4'd10; #1;
        chk("fips_rn10_const", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        round_num = 4'd9; #1;
        chk("fips_rn9_const", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
        check_slots("fips");

        // Second key, loaded from READY
        @(negedge clk);
        model_expand(128'h000102030405060708090a0b0c0d0e0f);
        load_pulse(128'h000102030405060708090a0b0c0d0e0f);
        expect_expansion("key2");
        chk("key2_rk10_const", round_key_10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        round_num = 4'd1; #1;
        chk("key2_rn1_const", round_key, 128'h549932d1f08557681093ed9cbe2c974e);
        check_slots("key2");

        // Restart mid-expansion: B lands 4 cycles after A
        @(negedge clk);
        key_a = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        load_pulse(key_a);
        repeat (3) @(negedge clk);
        model_expand(key_b);
        load_pulse(key_b);
        expect_expansion("restart");
        check_slots("restart");

        // Reset 5 cycles after a load discards everything
        @(negedge clk);
        load_pulse({$urandom, $urandom, $urandom, $urandom});
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("rst_mid");
        @(negedge clk);
        check_zero("rst_mid_hold");

        // Reset and load in the same cycle: reset wins
        reset      = 1'b1;
        key_load   = 1'b1;
        cipher_key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        reset    = 1'b0;
        key_load = 1'b0;
        check_zero("rst_vs_load");

        // Random keys, each re-keying the previous READY set
        for (int n = 0; n < 4; n++) begin
            key_a = {$urandom, $urandom, $urandom, $urandom};
            model_expand(key_a);
            load_pulse(key_a);
            expect_expansion($sformatf("rand%0d", n));
            check_slots($sformatf("rand%0d", n));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
